// File: rtl/alu_iterative.sv
// Multi-cycle EX-stage ALU: single-cycle logic/arith/compare ops and
// bit-serial shifts (one bit per cycle), with valid/ready on both sides.
module alu_iterative #(
  parameter  int DATA_WIDTH = 32,
  localparam int SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            Operation,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] ALUResult,
  output logic                  Zero,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef enum logic [1:0] {SH_LL, SH_RL, SH_RA} shkind_t;

  state_t                state, state_nxt;
  shkind_t               kind, kind_dec;
  logic                  accept;
  logic                  is_shift;
  logic [SHAMT_W-1:0]    shamt;
  logic [SHAMT_W-1:0]    cnt;
  logic [DATA_WIDTH-1:0] quick;
  logic [DATA_WIDTH-1:0] work;
  logic [DATA_WIDTH-1:0] work_step;

  // Operation decode and the single-cycle result (shift-by-0 passes SrcA).
  always_comb begin
    shamt    = SrcB[SHAMT_W-1:0];
    is_shift = 1'b0;
    kind_dec = SH_LL;
    quick    = '0;
    case (Operation)
      4'b0000: quick = SrcA & SrcB;
      4'b0001: quick = SrcA | SrcB;
      4'b0010: quick = SrcA + SrcB;
      4'b0011: quick = SrcA ^ SrcB;
      4'b0100: begin is_shift = 1'b1; kind_dec = SH_LL; quick = SrcA; end
      4'b0101: begin is_shift = 1'b1; kind_dec = SH_RL; quick = SrcA; end
      4'b0110: quick = SrcA - SrcB;
      4'b0111: begin is_shift = 1'b1; kind_dec = SH_RA; quick = SrcA; end
      4'b1000: quick = DATA_WIDTH'(SrcA == SrcB);
      4'b1100: quick = DATA_WIDTH'($signed(SrcA) < $signed(SrcB));
      4'b1110: quick = SrcA + SrcB;
      default: quick = '0;
    endcase
  end

  // One-bit step of the working register for the latched shift kind.
  always_comb begin
    work_step = work;
    case (kind)
      SH_LL:   work_step = {work[DATA_WIDTH-2:0], 1'b0};
      SH_RL:   work_step = {1'b0, work[DATA_WIDTH-1:1]};
      SH_RA:   work_step = {work[DATA_WIDTH-1], work[DATA_WIDTH-1:1]};
      default: work_step = work;
    endcase
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
    accept    = in_valid && in_ready;
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (is_shift && shamt != '0) ? SHIFT : DONE;
      SHIFT:   if (cnt == SHAMT_W'(1)) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Datapath: operand capture, iterative shift, result/Zero registers.
  // Result ports are written only on the last shift step so they never
  // show partial shift values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work      <= '0;
      cnt       <= '0;
      kind      <= SH_LL;
      ALUResult <= '0;
      Zero      <= 1'b0;
    end else begin
      if (accept) begin
        if (is_shift && shamt != '0) begin
          work <= SrcA;
          cnt  <= shamt;
          kind <= kind_dec;
        end else begin
          ALUResult <= quick;
          Zero      <= (quick == '0);
        end
      end
      if (state == SHIFT) begin
        work <= work_step;
        cnt  <= cnt - SHAMT_W'(1);
        if (cnt == SHAMT_W'(1)) begin
          ALUResult <= work_step;
          Zero      <= (work_step == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_iterative.sv
// Self-checking bench for alu_iterative: directed cases plus random ops
// against a plain-arithmetic reference model.
module tb_alu_iterative;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   Operation;
  logic [W-1:0] SrcA;
  logic [W-1:0] SrcB;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] ALUResult;
  logic         Zero;
  logic         busy;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  alu_iterative #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .Operation(Operation), .SrcA(SrcA), .SrcB(SrcB),
    .out_valid(out_valid), .out_ready(out_ready),
    .ALUResult(ALUResult), .Zero(Zero), .busy(busy)
  );

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int unsigned k;
    k = b % W;
    case (op)
      4'd0:        return a & b;
      4'd1:        return a | b;
      4'd2, 4'd14: return a + b;
      4'd3:        return a ^ b;
      4'd4:        return a << k;
      4'd5:        return a >> k;
      4'd6:        return a - b;
      4'd7:        return $signed(a) >>> k;
      4'd8:        return (a == b) ? 1 : 0;
      4'd12:       return ($signed(a) < $signed(b)) ? 1 : 0;
      default:     return '0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [3:0] op, input logic [W-1:0] b);
    if (op == 4'd4 || op == 4'd5 || op == 4'd7) return (b % W) + 1;
    return 1;
  endfunction

  // Issue one request, scramble inputs while waiting, hold the result for
  // 'hold' cycles, then transfer. Called #1 after a rising edge.
  task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int hold, output logic [W-1:0] res, output logic z, output int lat);
    check("in_ready_idle", W'(in_ready), W'(1));
    in_valid = 1'b1; Operation = op; SrcA = a; SrcB = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < W + 8) begin
      Operation = 4'($urandom); SrcA = $urandom; SrcB = $urandom;
      @(posedge clk); #1;
      lat++;
    end
    res = ALUResult; z = Zero;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_stable", ALUResult, res);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_check(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input int hold);
    logic [W-1:0] res, exp;
    logic z;
    int lat;
    exp = ref_alu(op, a, b);
    do_op(op, a, b, hold, res, z, lat);
    check({tag, "_result"}, res, exp);
    check({tag, "_zero"}, W'(z), W'(exp == '0));
    check({tag, "_latency"}, W'(lat), W'(ref_lat(op, b)));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, W'(in_ready), W'(1));
    check({tag, "_out_valid"}, W'(out_valid), W'(0));
    check({tag, "_result"}, ALUResult, '0);
    check({tag, "_zero"}, W'(Zero), W'(0));
    check({tag, "_busy"}, W'(busy), W'(0));
  endtask

  initial begin
    logic [3:0]   op;
    logic [W-1:0] a, b, res;
    logic         z;
    int           lat;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    Operation = '0; SrcA = '0; SrcB = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed single-cycle ops and shifts
    run_check("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'h1, 0);
    run_check("sub_zero", 4'b0110, 32'd5, 32'd5, 0);
    run_check("slt_neg", 4'b1100, 32'hFFFF_FFFF, 32'h1, 0);
    run_check("eq_same", 4'b1000, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 0);
    run_check("sra_31", 4'b0111, 32'h8000_0000, 32'd31, 0);
    run_check("srl_31", 4'b0101, 32'h8000_0000, 32'd31, 0);
    run_check("sll_0", 4'b0100, 32'h1, 32'h0, 0);
    run_check("sll_10", 4'b0100, 32'h1, 32'hFFFF_FC0A, 0);
    run_check("undef_f", 4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 0);
    run_check("add_alias", 4'b1110, 32'hFFFF_FFFF, 32'h2, 2);

    // Backpressure: second request held while result waits in DONE
    in_valid = 1'b1; Operation = 4'b0010; SrcA = 32'd10; SrcB = 32'd20;
    @(posedge clk); #1;
    Operation = 4'b0110; SrcA = 32'd100; SrcB = 32'd1;
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", W'(out_valid), W'(1));
      check("bp_in_ready", W'(in_ready), W'(0));
      check("bp_result", ALUResult, 32'd30);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_after_xfer_ready", W'(in_ready), W'(1));
    check("bp_after_xfer_valid", W'(out_valid), W'(0));
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_second_valid", W'(out_valid), W'(1));
    check("bp_second_result", ALUResult, 32'd99);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Random operations against the reference model
    for (int n = 0; n < 200; n++) begin
      op = 4'($urandom);
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
      run_check("rand", op, a, b, int'($urandom_range(0, 2)));
    end

    // Reset while in DONE
    do_op(4'b0010, 32'd3, 32'd4, 0, res, z, lat);
    in_valid = 1'b1; Operation = 4'b0010; SrcA = 32'd3; SrcB = 32'd4;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("rst_done_pre_valid", W'(out_valid), W'(1));
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_done");
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst_done_no_valid", W'(out_valid), W'(0));
      check("rst_done_ready", W'(in_ready), W'(1));
    end

    // Reset while in SHIFT (after a nonzero result so the clear is visible)
    run_check("pre_shift_add", 4'b0010, 32'd3, 32'd4, 0);
    in_valid = 1'b1; Operation = 4'b0100; SrcA = 32'h1; SrcB = 32'd20;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("rst_shift_busy", W'(busy), W'(1));
    check("rst_shift_held_result", ALUResult, 32'd7);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_shift");
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      check("rst_shift_no_valid", W'(out_valid), W'(0));
    end
    run_check("post_reset_xor", 4'b0011, 32'hF0F0_F0F0, 32'hFFFF_0000, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_iterative.md
Name: alu_iterative

Overview:
- Multi-cycle integer execution unit; consumes the 4-bit Operation code driven by the ALU controller, plus two operands.
- Logic, add/sub and compare ops complete in one cycle. Shifts run iteratively, 1 bit per cycle, so no barrel shifter is needed.
- Sits in the EX stage. Valid/ready handshake on both the request and the result sides lets the pipeline stall on long shifts.

Parameters:
- DATA_WIDTH, 32, operand/result width; must be a power of two, at least 8.
- SHAMT_W, $clog2(DATA_WIDTH), shift-amount width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request
- Operation  in  4  ALU operation code (table below)
- SrcA  in  DATA_WIDTH  operand A
- SrcB  in  DATA_WIDTH  operand B; low SHAMT_W bits are the shift amount for shifts
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- ALUResult  out  DATA_WIDTH  result
- Zero  out  1  ALUResult == 0, registered with ALUResult
- busy  out  1  state != IDLE

Behaviour:
- Reset (async assert, sync release): state=IDLE; in_ready=1; out_valid=0; ALUResult=0; Zero=0; busy=0; shift counter=0.
- Operation decode, fixed:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0011 XOR
  - 0100 SLL
  - 0101 SRL
  - 0110 SUB
  - 0111 SRA
  - 1000 EQ (result 1 if SrcA==SrcB, else 0)
  - 1100 SLT (signed)
  - 1110 ADD (alias)
  - all other codes → result 0, one-cycle path.
- Arithmetic: ADD/SUB wrap modulo 2^DATA_WIDTH, no carry/overflow output. SLT and SRA are two's-complement signed. Shift amount = SrcB[SHAMT_W-1:0]; upper SrcB bits are ignored.
- States: IDLE, SHIFT, DONE.
  - IDLE: in_ready=1. Accept when in_valid && in_ready (cycle N): latch operands and Operation.
    - Non-shift op, or shift with amount 0 → result registered, DONE at N+1.
    - Shift with amount k>0 → SHIFT, counter=k.
  - SHIFT: each cycle shift the working register 1 bit (SLL: zero fill low; SRL: zero fill high; SRA: sign fill) and decrement the counter. When the counter is 1, the shift in that cycle is the last, next state DONE.
  - SHIFT latency: k shift cycles (N+1..N+k); out_valid at cycle N+k+1.
  - DONE: out_valid=1. ALUResult and Zero are stable and held until out_ready=1, then → IDLE.
- in_ready=1 only in IDLE. A request presented while busy is not accepted and must be held by the producer.
- out_valid is asserted only in DONE. Result transfer happens on out_valid && out_ready. A new request can be accepted no earlier than the cycle after transfer.
- ALUResult/Zero are only meaningful when out_valid=1. They keep their last value after transfer and are never updated mid-shift on the ports; only the internal working register changes.
- Operand/Operation changes on the inputs after acceptance have no effect.
- rst_n asserted mid-shift or in DONE: immediately IDLE with reset values. The in-flight result is discarded and no out_valid pulse is produced after release.
- Latency summary:
  - one-cycle ops and shift-by-0: 1 cycle accept→out_valid.
  - shift by k: k+1 cycles.
  - worst case: DATA_WIDTH cycles (k=DATA_WIDTH-1).

Test Plan:
- Reset mid-op: assert rst_n=0 while in DONE and, separately, in SHIFT → all outputs at reset values; after release, in_ready=1 and no spurious out_valid.
- One-cycle ops: ADD 0x7FFFFFFF+1 → 0x80000000, Zero=0; SUB 5-5 → 0, Zero=1; SLT -1<1 → 1; EQ 0xA5A5A5A5 vs same → 1. All give out_valid exactly 1 cycle after accept.
- SRA 0x80000000 by 31 → 0xFFFFFFFF, out_valid 32 cycles after accept; SRL same operands → 0x00000001; SLL 1 by 0 → 1 after 1 cycle.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → ALUResult stable, in_ready=0, a second in_valid not accepted. Raise out_ready → transfer, then the second request is accepted the next cycle.
- Input stability: change SrcA/SrcB/Operation every cycle during a 10-bit SLL of 0x1 → result 0x400.
- Undefined code 1111 → ALUResult=0, Zero=1, 1-cycle latency.
